// File: rtl/vga_fetch_sched_if.sv
// ----------------------------------------------------------------------------
// vga_fetch_sched_if
// Bus bundle between the line-fetch scheduler, the shared burst memory port
// and the single writer (CPU/DMA).
//   mem_req   scheduler -> memory  burst request
//   mem_addr  scheduler -> memory  burst start word address
//   mem_len   scheduler -> memory  burst length in words
//   mem_src   scheduler -> memory  0 = display fetch, 1 = writer
//   mem_ack   memory -> scheduler  request accepted (with mem_req high)
//   mem_done  memory -> scheduler  accepted burst finished (1-cycle pulse)
//   wr_req    writer -> scheduler  writer request, held until wr_gnt
//   wr_addr   writer -> scheduler  writer burst start address
//   wr_gnt    scheduler -> writer  writer burst accepted (1-cycle pulse)
// Modports: master = scheduler view, slave = memory/writer view.
// ----------------------------------------------------------------------------
interface vga_fetch_sched_if #(
  parameter int ADDR_W = 24
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic              mem_src;
  logic              mem_ack;
  logic              mem_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_gnt;

  modport master (
    output mem_req, mem_addr, mem_len, mem_src, wr_gnt,
    input  mem_ack, mem_done, wr_req, wr_addr
  );

  modport slave (
    input  mem_req, mem_addr, mem_len, mem_src, wr_gnt,
    output mem_ack, mem_done, wr_req, wr_addr
  );
endinterface

// File: rtl/vga_fetch_sched.sv
// ----------------------------------------------------------------------------
// vga_fetch_sched
// Schedules display line-buffer refills from the shared frame buffer and
// arbitrates the single burst memory port between display (strict priority)
// and one writer. A line fetch is triggered at the end of the active part of
// each line that is followed by another active line, and at the last line of
// the frame for line 0.
// Ports:
//   clk       pixel clock
//   rst_n     asynchronous reset, active-low
//   sx, sy    raster position from the timing generator
//   enable    1 = schedule display fetches
//   underrun  1-cycle pulse: a new line was triggered before the previous
//             line's fetch finished
//   bus       memory port and writer handshake (master side)
// ----------------------------------------------------------------------------
module vga_fetch_sched #(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int V_TOTAL    = 1125,
  parameter int LINE_WORDS = 240,
  parameter int BURST      = 16,
  parameter int ADDR_W     = 24,
  parameter int FB_BASE    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [11:0]         sx,
  input  logic [10:0]         sy,
  input  logic                enable,
  output logic                underrun,
  vga_fetch_sched_if.master   bus
);

  localparam logic [7:0] NBURST = 8'(LINE_WORDS / BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_r, state_n;

  logic              mem_req_r,  mem_req_n;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_n;
  logic [7:0]        mem_len_r,  mem_len_n;
  logic              mem_src_r,  mem_src_n;
  logic              wr_gnt_r,   wr_gnt_n;
  logic              underrun_r;

  logic [7:0]        pending_r;
  logic [7:0]        idx_r;
  logic [10:0]       line_r;
  // Set while the burst in flight belongs to the line currently being fetched;
  // cleared when a retrigger or disable orphans it.
  logic              burst_counts_r;

  logic              trigger_s;
  logic [10:0]       trig_line_s;
  logic [10:0]       nxt_line_s;
  logic [7:0]        nxt_idx_s;
  logic [ADDR_W-1:0] disp_addr_s;
  logic              disp_avail_s;
  logic              launch_disp_s;
  logic              launch_wr_s;
  logic              done_counted_s;

  // Line-fetch trigger and the line it selects.
  always_comb begin
    trigger_s   = 1'b0;
    trig_line_s = 11'd0;
    if (enable && (sx == 12'(H_ACTIVE))) begin
      if (sy < 11'(V_ACTIVE - 1)) begin
        trigger_s   = 1'b1;
        trig_line_s = 11'(sy + 11'd1);
      end else if (sy == 11'(V_TOTAL - 1)) begin
        trigger_s   = 1'b1;
        trig_line_s = 11'd0;
      end else begin
        trigger_s   = 1'b0;
        trig_line_s = 11'd0;
      end
    end else begin
      trigger_s   = 1'b0;
      trig_line_s = 11'd0;
    end
  end

  // Display burst address; a trigger in this cycle is honoured immediately so
  // the writer cannot slip in ahead of a freshly triggered line.
  always_comb begin
    if (trigger_s) begin
      nxt_line_s = trig_line_s;
      nxt_idx_s  = 8'd0;
    end else begin
      nxt_line_s = line_r;
      nxt_idx_s  = idx_r;
    end
    disp_addr_s = ADDR_W'(FB_BASE)
                + ADDR_W'(nxt_line_s) * ADDR_W'(LINE_WORDS)
                + ADDR_W'(nxt_idx_s) * ADDR_W'(BURST);
    disp_avail_s   = enable && ((pending_r != 8'd0) || trigger_s);
    done_counted_s = (state_r == ST_WAIT) && bus.mem_done && burst_counts_r;
  end

  // Next-state and next-output logic for the port FSM.
  always_comb begin
    state_n       = state_r;
    mem_req_n     = mem_req_r;
    mem_addr_n    = mem_addr_r;
    mem_len_n     = mem_len_r;
    mem_src_n     = mem_src_r;
    wr_gnt_n      = 1'b0;
    launch_disp_s = 1'b0;
    launch_wr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (disp_avail_s) begin
          state_n       = ST_REQ;
          mem_req_n     = 1'b1;
          mem_addr_n    = disp_addr_s;
          mem_len_n     = 8'(BURST);
          mem_src_n     = 1'b0;
          launch_disp_s = 1'b1;
        end else if (bus.wr_req) begin
          state_n     = ST_REQ;
          mem_req_n   = 1'b1;
          mem_addr_n  = bus.wr_addr;
          mem_len_n   = 8'(BURST);
          mem_src_n   = 1'b1;
          launch_wr_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          state_n   = ST_WAIT;
          mem_req_n = 1'b0;
          wr_gnt_n  = mem_src_r;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.mem_done) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  // FSM state and registered port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
      mem_len_r  <= 8'd0;
      mem_src_r  <= 1'b0;
      wr_gnt_r   <= 1'b0;
    end else begin
      state_r    <= state_n;
      mem_req_r  <= mem_req_n;
      mem_addr_r <= mem_addr_n;
      mem_len_r  <= mem_len_n;
      mem_src_r  <= mem_src_n;
      wr_gnt_r   <= wr_gnt_n;
    end
  end

  // Line fetch bookkeeping: reload on trigger wins over a same-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r      <= 8'd0;
      idx_r          <= 8'd0;
      line_r         <= 11'd0;
      burst_counts_r <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      underrun_r <= trigger_s && (pending_r != 8'd0);

      if (trigger_s) begin
        pending_r <= NBURST;
        idx_r     <= 8'd0;
        line_r    <= trig_line_s;
      end else if (!enable) begin
        pending_r <= 8'd0;
      end else if (done_counted_s) begin
        pending_r <= pending_r - 8'd1;
        idx_r     <= idx_r + 8'd1;
      end else begin
        pending_r <= pending_r;
      end

      if (launch_disp_s) begin
        burst_counts_r <= 1'b1;
      end else if (launch_wr_s || trigger_s || !enable) begin
        burst_counts_r <= 1'b0;
      end else begin
        burst_counts_r <= burst_counts_r;
      end
    end
  end

  assign bus.mem_req  = mem_req_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_len  = mem_len_r;
  assign bus.mem_src  = mem_src_r;
  assign bus.wr_gnt   = wr_gnt_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_vga_fetch_sched.sv
// ----------------------------------------------------------------------------
// tb_vga_fetch_sched
// Directed bench for vga_fetch_sched. The bench plays timing generator,
// memory controller and writer; inputs change and outputs are sampled on the
// falling clock edge.
// ----------------------------------------------------------------------------
module tb_vga_fetch_sched;

  localparam int ADDR_W = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sx;
  logic [10:0] sy;
  logic        enable;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  vga_fetch_sched_if #(.ADDR_W(ADDR_W)) bus ();

  vga_fetch_sched #(
    .H_ACTIVE(1920), .V_ACTIVE(1080), .V_TOTAL(1125),
    .LINE_WORDS(240), .BURST(16), .ADDR_W(ADDR_W), .FB_BASE(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sx(sx),
    .sy(sy),
    .enable(enable),
    .underrun(underrun),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present sx==1920 for exactly one rising edge.
  task automatic fire(input int y);
    sx = 12'd1920;
    sy = 11'(y);
    tick();
    sx = 12'd0;
  endtask

  task automatic wait_req(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_req_seen"}, {31'd0, ok}, 32'd1);
  endtask

  // Accept one burst, check its attributes; done follows ack after lat cycles
  // unless withheld.
  task automatic serve(input string tag, input logic [23:0] addr, input logic src,
                       input int lat, input bit withhold);
    bit ok;
    wait_req(tag, ok);
    if (ok) begin
      check({tag, "_addr"}, {8'd0, bus.mem_addr}, {8'd0, addr});
      check({tag, "_src"},  {31'd0, bus.mem_src}, {31'd0, src});
      check({tag, "_len"},  {24'd0, bus.mem_len}, 32'd16);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check({tag, "_req_drop"}, {31'd0, bus.mem_req}, 32'd0);
      check({tag, "_gnt"}, {31'd0, bus.wr_gnt}, {31'd0, src});
      if (src) bus.wr_req = 1'b0;
      tick();
      check({tag, "_gnt_end"}, {31'd0, bus.wr_gnt}, 32'd0);
      if (!withhold) begin
        repeat (lat - 2) tick();
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
      end
    end
  endtask

  // No request at all for n cycles.
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      seen = seen | bus.mem_req;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  task automatic serve_line(input string tag, input logic [23:0] base, input int first);
    for (int i = first; i < 15; i++) begin
      serve($sformatf("%s%0d", tag, i), base + 24'(16 * i), 1'b0, 20, 1'b0);
    end
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    bit ok;
    rst_n        = 1'b0;
    sx           = 12'd0;
    sy           = 11'd0;
    enable       = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_req",  {31'd0, bus.mem_req}, 32'd0);
    check("rst_addr", {8'd0, bus.mem_addr}, 32'd0);
    check("rst_len",  {24'd0, bus.mem_len}, 32'd0);
    check("rst_src",  {31'd0, bus.mem_src}, 32'd0);
    check("rst_gnt",  {31'd0, bus.wr_gnt},  32'd0);
    check("rst_und",  {31'd0, underrun},    32'd0);

    // Line 1 fetch at sy=0, must fit in one line period.
    enable = 1'b1;
    t0 = cyc;
    fire(0);
    serve_line("l1_b", 24'd240, 0);
    check("l1_in_time", {31'd0, ((cyc - t0) < 2200)}, 32'd1);
    quiet("l1_no_extra", 30);

    // Last line of frame prefetches line 0.
    fire(1124);
    serve_line("l0_b", 24'd0, 0);
    quiet("l0_no_extra", 30);

    // Writer alone.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h001000;
    serve("wr_only", 24'h001000, 1'b1, 20, 1'b0);
    quiet("wr_no_extra", 30);

    // Writer held while display fetches line 6: display goes first, whole line.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h002000;
    fire(5);
    serve_line("l6_b", 24'd1440, 0);
    serve("wr_after", 24'h002000, 1'b1, 20, 1'b0);
    quiet("wr2_no_extra", 30);

    // Underrun: line 11 burst 0 never finishes before next trigger.
    fire(10);
    serve("u_b0", 24'd2640, 1'b0, 20, 1'b1);
    repeat (3000) tick();
    check("u_stall_req", {31'd0, bus.mem_req}, 32'd0);
    check("u_pre_und",   {31'd0, underrun},    32'd0);
    fire(11);
    check("u_pulse", {31'd0, underrun}, 32'd1);
    tick();
    check("u_pulse_end", {31'd0, underrun}, 32'd0);
    check("u_still_wait", {31'd0, bus.mem_req}, 32'd0);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    serve_line("l12_b", 24'd2880, 0);
    quiet("l12_no_extra", 30);

    // Disable during burst 5 of line 21; writer still served afterwards.
    fire(20);
    serve_line_part: for (int i = 0; i < 4; i++) begin
      serve($sformatf("l21_b%0d", i), 24'd5040 + 24'(16 * i), 1'b0, 20, 1'b0);
    end
    serve("l21_b4", 24'd5104, 1'b0, 20, 1'b1);
    enable = 1'b0;
    repeat (5) tick();
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    quiet("dis_no_disp", 40);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h003000;
    serve("dis_wr", 24'h003000, 1'b1, 20, 1'b0);
    quiet("dis_no_extra", 20);

    // Asynchronous reset while a burst is requested.
    enable = 1'b1;
    fire(40);
    wait_req("rst_mid", ok);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req",  {31'd0, bus.mem_req}, 32'd0);
    check("rst_mid_addr", {8'd0, bus.mem_addr}, 32'd0);
    check("rst_mid_len",  {24'd0, bus.mem_len}, 32'd0);
    tick();
    rst_n = 1'b1;
    quiet("rst_mid_quiet", 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
